usb3_ep0_drv: RTL and testbench
===============================

Name: usb3_ep0_drv

Overview:
- Protocol-layer-side driver for the endpoint-0 buffer interface. It is the initiator for the control endpoint's buffer handshakes.
- Receives a setup packet as a 32-bit word stream from the link RX path and writes it into the EP0 input buffer. It then commits the buffer and waits for the endpoint's response.
- Streams the response data (descriptor, config byte or zero-length) to the TX path, then re-arms the endpoint output buffer.

Parameters:
- RD_LAT, 2: cycles from buf_out_addr change to valid buf_out_q (1..3).
- MAX_WORDS, 16: maximum setup words accepted per packet (buffer addr 0..MAX_WORDS-1).
- TMO_CYC, 4096: wait-timeout in local_clk cycles (used only with the optional feature).

Ports:
- local_clk  in  1  sole clock
- reset_n  in  1  asynchronous active-low reset
- rx_valid  in  1  setup word valid
- rx_data  in  32  setup word, first byte in [31:24]
- rx_last  in  1  final word of setup packet
- rx_ready  out  1  driver accepts rx word
- buf_in_addr  out  9  endpoint input buffer write address
- buf_in_data  out  32  endpoint input buffer write data
- buf_in_wren  out  1  write strobe
- buf_in_ready  in  1  endpoint input buffer free
- buf_in_commit  out  1  commit request (level, held until ack)
- buf_in_commit_len  out  11  committed byte count
- buf_in_commit_ack  in  1  commit acknowledge
- buf_out_addr  out  9  endpoint output buffer read word address
- buf_out_q  in  32  endpoint output read data
- buf_out_len  in  11  response length in bytes
- buf_out_hasdata  in  1  response available
- buf_out_arm  out  1  arm request (level, held until ack)
- buf_out_arm_ack  in  1  arm acknowledge
- tx_valid  out  1  response word valid
- tx_data  out  32  response word
- tx_keep  out  4  byte enables, [3]=first byte
- tx_last  out  1  last response word
- tx_ready  in  1  TX accepts word
- tx_zlp  out  1  one-cycle pulse: zero-length response
- req_stall  out  1  one-cycle pulse: endpoint released buffer without data
- busy  out  1  FSM not in IDLE
- err_overflow  out  1  sticky: more than MAX_WORDS setup words received
- err_timeout  out  1  sticky: wait timeout expired

Behaviour:
- Reset (async, reset_n=0) values:
  - All outputs 0.
  - State IDLE, word counter 0.
  - Sticky errors are cleared only by reset.
- IDLE:
  - rx_ready = buf_in_ready.
  - On rx_valid&rx_ready: write the word at addr 0, go to WRITE.
  - If that word has rx_last, go straight to COMMIT.
- WRITE:
  - Each accepted word drives buf_in_wren=1, buf_in_addr=wcnt, buf_in_data=rx_data in the same cycle; wcnt increments.
  - Words with wcnt>=MAX_WORDS are accepted but not written, and set err_overflow.
  - The rx_last word ends the packet: go to COMMIT.
- COMMIT:
  - buf_in_commit_len = 4*min(wcnt,MAX_WORDS). wcnt saturates at MAX_WORDS.
  - buf_in_commit=1 until the first cycle buf_in_commit_ack=1; it deasserts the next cycle.
  - Then go to WAIT_ACKLOW.
- WAIT_ACKLOW: wait for buf_in_commit_ack=0, then go to WAIT_RESP.
- WAIT_RESP: wait for buf_in_ready=1.
  - If buf_out_hasdata=1 in the same cycle: latch len=buf_out_len.
    - len==0: pulse tx_zlp, go to ARM.
    - Otherwise: words=ceil(len/4), raddr=0, go to READ.
  - If buf_out_hasdata=0: pulse req_stall, go to IDLE.
- READ:
  - Drive buf_out_addr=raddr, wait RD_LAT cycles, capture buf_out_q, go to SEND.
- SEND:
  - Assert tx_valid with the captured word.
  - tx_last=1 on word words-1.
  - tx_keep=4'b1111, except on the last word, where it is selected by len[1:0]: 0→1111, 1→1000, 2→1100, 3→1110.
  - On tx_ready: raddr++; go to READ, or to ARM after the last word.
  - tx_valid and tx_data are stable until accepted.
- ARM:
  - buf_out_arm=1 until buf_out_arm_ack=1, then deassert.
  - Wait for ack low, go to IDLE.
- Throughput: one word per RD_LAT+2 cycles when tx_ready is held high.
- Length >512 words is impossible: 11-bit len gives at most 512 words, so raddr fits in 9 bits.
- rx_data presented while not in IDLE/WRITE is not accepted (rx_ready=0).
- busy=1 in every state except IDLE.
- Reset mid-operation:
  - Returns immediately to IDLE with commit, arm and tx deasserted.
  - No partial word is emitted after reset.

Optional Feature:
- USB3_EP0_DRV_TIMEOUT_EN defined:
  - A counter runs in COMMIT, WAIT_ACKLOW, WAIT_RESP and ARM.
  - It is cleared on every state change.
  - At TMO_CYC cycles: set err_timeout, drop commit/arm, go to IDLE.
- Undefined:
  - No counter; waits are unbounded.
  - err_timeout is tied to 0.
  - TMO_CYC is unused.

Test Plan:
- 2-word GET_DESCRIPTOR(0x0100, wLength=0x0040); endpoint returns len=18 → 5 tx words, last tx_keep=1100, tx_last on word 4, then one arm handshake.
- SET_ADDRESS 2-word packet; endpoint returns hasdata with len=0 → buf_in_commit_len=8, exactly one tx_zlp pulse, no tx_valid, arm performed.
- Unsupported request; endpoint raises buf_in_ready without hasdata → req_stall pulse, no arm, busy=0 next cycle.
- tx_ready held low 10 cycles mid-response → tx_data and tx_keep unchanged; total word count unchanged.
- 18-word setup packet with MAX_WORDS=16 → 16 writes, err_overflow=1, commit_len=64.
- With USB3_EP0_DRV_TIMEOUT_EN and TMO_CYC=32, commit ack never returned → err_timeout=1 at cycle 32, buf_in_commit=0, state IDLE.
- Reset asserted during SEND → all outputs 0 immediately.

Source files
------------

// File: rtl/usb3_ep0_drv.sv
// rtl/usb3_ep0_drv.sv - EP0 buffer driver: setup write, commit, response read/stream, re-arm
// Optional feature macro: USB3_EP0_DRV_TIMEOUT_EN bounds the handshake waits to TMO_CYC cycles.
module usb3_ep0_drv #(
    parameter int RD_LAT    = 2,
    parameter int MAX_WORDS = 16,
    parameter int TMO_CYC   = 4096
) (
    input  logic        local_clk,
    input  logic        reset_n,
    input  logic        rx_valid,
    input  logic [31:0] rx_data,
    input  logic        rx_last,
    output logic        rx_ready,
    output logic [8:0]  buf_in_addr,
    output logic [31:0] buf_in_data,
    output logic        buf_in_wren,
    input  logic        buf_in_ready,
    output logic        buf_in_commit,
    output logic [10:0] buf_in_commit_len,
    input  logic        buf_in_commit_ack,
    output logic [8:0]  buf_out_addr,
    input  logic [31:0] buf_out_q,
    input  logic [10:0] buf_out_len,
    input  logic        buf_out_hasdata,
    output logic        buf_out_arm,
    input  logic        buf_out_arm_ack,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    output logic [3:0]  tx_keep,
    output logic        tx_last,
    input  logic        tx_ready,
    output logic        tx_zlp,
    output logic        req_stall,
    output logic        busy,
    output logic        err_overflow,
    output logic        err_timeout
);

    localparam logic [3:0] S_IDLE        = 4'd0;
    localparam logic [3:0] S_WRITE       = 4'd1;
    localparam logic [3:0] S_COMMIT      = 4'd2;
    localparam logic [3:0] S_WAIT_ACKLOW = 4'd3;
    localparam logic [3:0] S_WAIT_RESP   = 4'd4;
    localparam logic [3:0] S_READ        = 4'd5;
    localparam logic [3:0] S_SEND        = 4'd6;
    localparam logic [3:0] S_ARM         = 4'd7;
    localparam logic [3:0] S_ARM_ACKLOW  = 4'd8;

    localparam int WCNT_W = $clog2(MAX_WORDS + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MAX_WORDS);
    localparam int LAT_W = $clog2(RD_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_END = LAT_W'(RD_LAT);

    logic [3:0]        state;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcnt_nxt;
    logic [10:0]       len;
    logic [9:0]        words;
    logic [8:0]        raddr;
    logic [LAT_W-1:0]  rd_cnt;
    logic              rx_take;
    logic              wr_ok;
    logic              tmo_hit;
    logic              is_last_word;
    logic [3:0]        last_keep;

    // rx_ready is gated by reset so every output reads 0 while reset is held
    always_comb begin
        rx_ready = 1'b0;
        if (reset_n) begin
            if (state == S_IDLE)
                rx_ready = buf_in_ready;
            else if (state == S_WRITE)
                rx_ready = 1'b1;
        end
    end

    assign rx_take      = rx_valid & rx_ready;
    assign wr_ok        = rx_take & (wcnt < WCNT_MAX);
    assign buf_in_wren  = wr_ok;
    assign buf_in_addr  = wr_ok ? 9'(wcnt) : 9'd0;
    assign buf_in_data  = wr_ok ? rx_data : 32'd0;
    assign wcnt_nxt     = (wcnt == WCNT_MAX) ? wcnt : wcnt + 1'b1;
    assign buf_out_addr = raddr;
    assign busy         = (state != S_IDLE);
    assign is_last_word = ({1'b0, raddr} == words - 10'd1);

    always_comb begin
        case (len[1:0])
            2'd1:    last_keep = 4'b1000;
            2'd2:    last_keep = 4'b1100;
            2'd3:    last_keep = 4'b1110;
            default: last_keep = 4'b1111;
        endcase
    end

`ifdef USB3_EP0_DRV_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);

    logic [3:0]       state_d;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_eff;
    logic             waiting;
    logic             err_tmo_q;

    assign waiting = (state == S_COMMIT) || (state == S_WAIT_ACKLOW) || (state == S_WAIT_RESP)
                  || (state == S_ARM) || (state == S_ARM_ACKLOW);
    // The count restarts from zero in the first cycle of any new state
    assign tmo_eff = (state == state_d) ? tmo_cnt : '0;
    assign tmo_hit = waiting && (tmo_eff == TMO_W'(TMO_CYC - 1));
    assign err_timeout = err_tmo_q;

    always_ff @(posedge local_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_d   <= S_IDLE;
            tmo_cnt   <= '0;
            err_tmo_q <= 1'b0;
        end else begin
            state_d <= state;
            tmo_cnt <= waiting ? tmo_eff + 1'b1 : '0;
            if (tmo_hit)
                err_tmo_q <= 1'b1;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge local_clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= S_IDLE;
            wcnt              <= '0;
            len               <= '0;
            words             <= '0;
            raddr             <= '0;
            rd_cnt            <= '0;
            buf_in_commit     <= 1'b0;
            buf_in_commit_len <= '0;
            buf_out_arm       <= 1'b0;
            tx_valid          <= 1'b0;
            tx_data           <= '0;
            tx_keep           <= '0;
            tx_last           <= 1'b0;
            tx_zlp            <= 1'b0;
            req_stall         <= 1'b0;
            err_overflow      <= 1'b0;
        end else begin
            tx_zlp    <= 1'b0;
            req_stall <= 1'b0;
            if (rx_take && !wr_ok)
                err_overflow <= 1'b1;
            if (tmo_hit) begin
                state             <= S_IDLE;
                buf_in_commit     <= 1'b0;
                buf_in_commit_len <= '0;
                buf_out_arm       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_WRITE: begin
                        if (rx_take) begin
                            if (rx_last) begin
                                // Length is latched here so wcnt can restart for the next packet
                                wcnt              <= '0;
                                buf_in_commit     <= 1'b1;
                                buf_in_commit_len <= 11'({wcnt_nxt, 2'b00});
                                state             <= S_COMMIT;
                            end else begin
                                wcnt  <= wcnt_nxt;
                                state <= S_WRITE;
                            end
                        end
                    end
                    S_COMMIT: begin
                        if (buf_in_commit_ack) begin
                            buf_in_commit     <= 1'b0;
                            buf_in_commit_len <= '0;
                            state             <= S_WAIT_ACKLOW;
                        end
                    end
                    S_WAIT_ACKLOW: begin
                        if (!buf_in_commit_ack)
                            state <= S_WAIT_RESP;
                    end
                    S_WAIT_RESP: begin
                        if (buf_in_ready) begin
                            if (buf_out_hasdata) begin
                                len <= buf_out_len;
                                if (buf_out_len == 11'd0) begin
                                    tx_zlp      <= 1'b1;
                                    buf_out_arm <= 1'b1;
                                    state       <= S_ARM;
                                end else begin
                                    words  <= 10'(({1'b0, buf_out_len} + 12'd3) >> 2);
                                    raddr  <= '0;
                                    rd_cnt <= '0;
                                    state  <= S_READ;
                                end
                            end else begin
                                req_stall <= 1'b1;
                                state     <= S_IDLE;
                            end
                        end
                    end
                    S_READ: begin
                        if (rd_cnt == LAT_END) begin
                            tx_valid <= 1'b1;
                            tx_data  <= buf_out_q;
                            tx_last  <= is_last_word;
                            tx_keep  <= is_last_word ? last_keep : 4'b1111;
                            state    <= S_SEND;
                        end else begin
                            rd_cnt <= rd_cnt + 1'b1;
                        end
                    end
                    S_SEND: begin
                        if (tx_ready) begin
                            tx_valid <= 1'b0;
                            tx_data  <= '0;
                            tx_keep  <= '0;
                            tx_last  <= 1'b0;
                            if (tx_last) begin
                                raddr       <= '0;
                                buf_out_arm <= 1'b1;
                                state       <= S_ARM;
                            end else begin
                                raddr  <= raddr + 1'b1;
                                rd_cnt <= '0;
                                state  <= S_READ;
                            end
                        end
                    end
                    S_ARM: begin
                        if (buf_out_arm_ack) begin
                            buf_out_arm <= 1'b0;
                            state       <= S_ARM_ACKLOW;
                        end
                    end
                    S_ARM_ACKLOW: begin
                        if (!buf_out_arm_ack)
                            state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb3_ep0_drv.sv
// tb/tb_usb3_ep0_drv.sv - self-checking bench for usb3_ep0_drv with an endpoint model
module tb_usb3_ep0_drv;
    localparam int RD_LAT = 2, MAX_WORDS = 16, TMO_CYC = 32;

    logic        local_clk = 1'b0, reset_n = 1'b0;
    logic        rx_valid = 1'b0, rx_last = 1'b0, rx_ready;
    logic [31:0] rx_data = '0;
    logic [8:0]  buf_in_addr;
    logic [31:0] buf_in_data;
    logic        buf_in_wren, buf_in_commit;
    logic        buf_in_ready = 1'b0, buf_in_commit_ack = 1'b0;
    logic [10:0] buf_in_commit_len;
    logic [8:0]  buf_out_addr;
    logic [31:0] buf_out_q;
    logic [10:0] buf_out_len = '0;
    logic        buf_out_hasdata = 1'b0, buf_out_arm, buf_out_arm_ack = 1'b0;
    logic        tx_valid, tx_last, tx_ready = 1'b0;
    logic [31:0] tx_data;
    logic [3:0]  tx_keep;
    logic        tx_zlp, req_stall, busy, err_overflow, err_timeout;

    int n_vec, n_err;
    bit exp_ovf, bp_rand, hold_tx;
    logic [31:0] setup_w [0:31];
    logic [31:0] resp_mem [0:511];
    logic [8:0]  pipe [0:RD_LAT-1];
    logic [31:0] exp_wr [$];
    logic [8:0]  wr_addr [$];
    logic [31:0] wr_data [$];
    logic [31:0] txd [$];
    logic [3:0]  txk [$];
    logic        txl [$];
    int zlp_cnt, stall_cnt, txv_cnt, arm_rise;
    logic arm_prev;

    usb3_ep0_drv #(.RD_LAT(RD_LAT), .MAX_WORDS(MAX_WORDS), .TMO_CYC(TMO_CYC)) dut (
        .local_clk(local_clk), .reset_n(reset_n),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last), .rx_ready(rx_ready),
        .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
        .buf_in_ready(buf_in_ready), .buf_in_commit(buf_in_commit),
        .buf_in_commit_len(buf_in_commit_len), .buf_in_commit_ack(buf_in_commit_ack),
        .buf_out_addr(buf_out_addr), .buf_out_q(buf_out_q), .buf_out_len(buf_out_len),
        .buf_out_hasdata(buf_out_hasdata), .buf_out_arm(buf_out_arm),
        .buf_out_arm_ack(buf_out_arm_ack), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_keep(tx_keep), .tx_last(tx_last), .tx_ready(tx_ready), .tx_zlp(tx_zlp),
        .req_stall(req_stall), .busy(busy), .err_overflow(err_overflow), .err_timeout(err_timeout)
    );

    always #5 local_clk = ~local_clk;

    // Endpoint output buffer: read data follows the address by RD_LAT clocks
    always @(posedge local_clk) begin
        pipe[0] <= buf_out_addr;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign buf_out_q = resp_mem[pipe[RD_LAT-1]];

    always @(posedge local_clk) begin
        #1;
        if (hold_tx) tx_ready = 1'b0;
        else if (bp_rand) tx_ready = ($urandom_range(0, 1) != 0);
        else tx_ready = 1'b1;
    end

    always @(negedge local_clk) begin
        if (reset_n) begin
            if (buf_in_wren) begin wr_addr.push_back(buf_in_addr); wr_data.push_back(buf_in_data); end
            if (tx_valid) txv_cnt++;
            if (tx_valid && tx_ready) begin txd.push_back(tx_data); txk.push_back(tx_keep); txl.push_back(tx_last); end
            if (tx_zlp) zlp_cnt++;
            if (req_stall) stall_cnt++;
            if (buf_out_arm && !arm_prev) arm_rise++;
        end
        arm_prev = buf_out_arm;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic clear_mon();
        wr_addr.delete(); wr_data.delete(); txd.delete(); txk.delete(); txl.delete();
        zlp_cnt = 0; stall_cnt = 0; txv_cnt = 0; arm_rise = 0;
    endtask

    task automatic send_setup(input int n);
        int t;
        clear_mon(); exp_wr.delete();
        buf_in_ready = 1'b1;
        if (n > MAX_WORDS) exp_ovf = 1'b1;
        @(posedge local_clk); #1;
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1; rx_data = setup_w[i]; rx_last = (i == n - 1);
            if (i < MAX_WORDS) exp_wr.push_back(setup_w[i]);
            t = 0;
            @(negedge local_clk);
            while (!rx_ready && t < 50) begin t++; @(negedge local_clk); end
            if (!rx_ready) begin
                n_vec++; n_err++;
                $display("FAIL rx_accept word %0d: rx_ready=%b required 1", i, rx_ready);
            end
            @(posedge local_clk); #1;
        end
        rx_valid = 1'b0; rx_last = 1'b0; rx_data = '0;
    endtask

    task automatic check_writes();
        @(negedge local_clk);
        n_vec++;
        if (wr_data.size() != exp_wr.size()) begin
            n_err++;
            $display("FAIL write_count: got %0d required %0d", wr_data.size(), exp_wr.size());
        end else begin
            foreach (exp_wr[i]) begin
                n_vec++;
                if (wr_addr[i] !== 9'(i) || wr_data[i] !== exp_wr[i]) begin
                    n_err++;
                    $display("FAIL write %0d: got addr %0d data %h required addr %0d data %h",
                             i, wr_addr[i], wr_data[i], i, exp_wr[i]);
                end
            end
        end
    endtask

    task automatic do_commit(input int exp_len);
        int t;
        t = 0;
        while (buf_in_commit !== 1'b1 && t < 50) begin t++; @(negedge local_clk); end
        n_vec++;
        if (buf_in_commit !== 1'b1 || buf_in_commit_len !== 11'(exp_len)) begin
            n_err++;
            $display("FAIL commit: got commit=%b len=%0d required commit=1 len=%0d",
                     buf_in_commit, buf_in_commit_len, exp_len);
        end
        repeat ($urandom_range(0, 3)) @(negedge local_clk);
        @(posedge local_clk); #1;
        buf_in_commit_ack = 1'b1; buf_in_ready = 1'b0;
        @(negedge local_clk);
        @(negedge local_clk);
        n_vec++;
        if (buf_in_commit !== 1'b0) begin
            n_err++; $display("FAIL commit_drop: got %b required 0", buf_in_commit);
        end
        @(posedge local_clk); #1;
        buf_in_commit_ack = 1'b0;
    endtask

    task automatic respond(input bit has, input int len);
        for (int i = 0; i < (len + 3) / 4; i++) resp_mem[i] = $urandom;
        repeat ($urandom_range(0, 4)) @(posedge local_clk);
        #1;
        buf_out_len = 11'(len); buf_out_hasdata = has; buf_in_ready = 1'b1;
    endtask

    task automatic finish_resp(input bit has, input int len);
        int t, nw, bytes;
        logic [3:0] ek;
        nw = (len + 3) / 4;
        t = 0;
        if (!has) begin
            while (req_stall !== 1'b1 && t < 50) begin t++; @(negedge local_clk); end
            n_vec++;
            if (req_stall !== 1'b1 || busy !== 1'b0) begin
                n_err++; $display("FAIL stall: got req_stall=%b busy=%b required 1 0", req_stall, busy);
            end
            repeat (3) @(negedge local_clk);
            n_vec++;
            if (stall_cnt != 1 || arm_rise != 0 || txv_cnt != 0) begin
                n_err++;
                $display("FAIL stall_side: got stalls=%0d arms=%0d txv=%0d required 1 0 0",
                         stall_cnt, arm_rise, txv_cnt);
            end
        end else begin
            while (buf_out_arm !== 1'b1 && t < 60 * nw + 60) begin t++; @(negedge local_clk); end
            n_vec++;
            if (buf_out_arm !== 1'b1) begin
                n_err++; $display("FAIL arm_req: got %b required 1", buf_out_arm);
            end
            repeat ($urandom_range(0, 2)) @(negedge local_clk);
            @(posedge local_clk); #1;
            buf_out_arm_ack = 1'b1;
            @(negedge local_clk);
            @(negedge local_clk);
            n_vec++;
            if (buf_out_arm !== 1'b0) begin
                n_err++; $display("FAIL arm_drop: got %b required 0", buf_out_arm);
            end
            @(posedge local_clk); #1;
            buf_out_arm_ack = 1'b0;
            t = 0;
            @(negedge local_clk);
            while (busy !== 1'b0 && t < 10) begin t++; @(negedge local_clk); end
            n_vec++;
            if (busy !== 1'b0 || arm_rise != 1 || zlp_cnt != (len == 0 ? 1 : 0)) begin
                n_err++;
                $display("FAIL resp_end: got busy=%b arms=%0d zlps=%0d required 0 1 %0d",
                         busy, arm_rise, zlp_cnt, (len == 0 ? 1 : 0));
            end
            n_vec++;
            if (txd.size() != nw || txv_cnt < nw) begin
                n_err++; $display("FAIL tx_count: got %0d required %0d", txd.size(), nw);
            end else begin
                for (int i = 0; i < nw; i++) begin
                    bytes = (i == nw - 1) ? len - 4 * i : 4;
                    ek = 4'b1111 << (4 - bytes);
                    n_vec++;
                    if (txd[i] !== resp_mem[i] || txk[i] !== ek || txl[i] !== (i == nw - 1)) begin
                        n_err++;
                        $display("FAIL tx_word %0d: got %h/%b/%b required %h/%b/%b", i,
                                 txd[i], txk[i], txl[i], resp_mem[i], ek, (i == nw - 1));
                    end
                end
            end
        end
        buf_out_hasdata = 1'b0;
    endtask

    task automatic run_xfer(input int n, input bit has, input int len);
        send_setup(n);
        check_writes();
        do_commit(4 * ((n < MAX_WORDS) ? n : MAX_WORDS));
        respond(has, len);
        finish_resp(has, len);
        n_vec++;
        if (err_overflow !== exp_ovf) begin
            n_err++; $display("FAIL overflow_flag: got %b required %b", err_overflow, exp_ovf);
        end
    endtask

    task automatic test_reset();
        buf_in_ready = 1'b1;
        repeat (3) @(negedge local_clk);
        n_vec++;
        if ({rx_ready, buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
             buf_out_addr, buf_out_arm, tx_valid, tx_data, tx_keep, tx_last, tx_zlp, req_stall,
             busy, err_overflow, err_timeout} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got nonzero required all 0");
        end
        @(posedge local_clk); #1;
        reset_n = 1'b1;
        @(negedge local_clk);
        n_vec++;
        if (rx_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL post_reset: got rx_ready=%b busy=%b required 1 0", rx_ready, busy);
        end
    endtask

    task automatic test_get_descriptor();
        setup_w[0] = 32'h8006_0001; setup_w[1] = 32'h0000_4000;
        run_xfer(2, 1'b1, 18);
    endtask

    task automatic test_set_address();
        setup_w[0] = 32'h0005_0200; setup_w[1] = 32'h0000_0000;
        run_xfer(2, 1'b1, 0);
        n_vec++;
        if (txv_cnt != 0) begin
            n_err++; $display("FAIL zlp_no_data: got %0d tx_valid cycles required 0", txv_cnt);
        end
    endtask

    task automatic test_stall();
        setup_w[0] = 32'h00FF_0000; setup_w[1] = $urandom;
        run_xfer(2, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        int t, n0;
        setup_w[0] = $urandom; setup_w[1] = $urandom;
        send_setup(2);
        check_writes();
        do_commit(8);
        respond(1'b1, 40);
        t = 0;
        while (txd.size() < 3 && t < 200) begin t++; @(negedge local_clk); end
        hold_tx = 1'b1;
        @(posedge local_clk); #2;
        t = 0;
        @(negedge local_clk);
        while (tx_valid !== 1'b1 && t < 20) begin t++; @(negedge local_clk); end
        n0 = txd.size();
        for (int c = 0; c < 10; c++) begin
            n_vec++;
            if (tx_valid !== 1'b1 || tx_data !== resp_mem[n0] || tx_keep !== 4'b1111) begin
                n_err++;
                $display("FAIL hold cycle %0d: got %b/%h/%b required 1/%h/1111",
                         c, tx_valid, tx_data, tx_keep, resp_mem[n0]);
            end
            @(negedge local_clk);
        end
        hold_tx = 1'b0;
        finish_resp(1'b1, 40);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 18; i++) setup_w[i] = $urandom;
        run_xfer(18, 1'b0, 0);
    endtask

    task automatic test_random();
        int n, len;
        bit has;
        bp_rand = 1'b1;
        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) setup_w[i] = $urandom;
            has = ($urandom_range(0, 3) != 0);
            len = (has && $urandom_range(0, 3) != 0) ? $urandom_range(1, 80) : 0;
            run_xfer(n, has, len);
        end
        bp_rand = 1'b0;
    endtask

    task automatic test_timeout();
`ifdef USB3_EP0_DRV_TIMEOUT_EN
        int c;
        setup_w[0] = $urandom;
        send_setup(1);
        c = 0;
        while (buf_in_commit === 1'b1 && c < 100) begin c++; @(negedge local_clk); end
        n_vec++;
        if (c != TMO_CYC || err_timeout !== 1'b1 || busy !== 1'b0 || buf_in_commit !== 1'b0) begin
            n_err++;
            $display("FAIL timeout: got cycles=%0d err=%b busy=%b commit=%b required %0d 1 0 0",
                     c, err_timeout, busy, buf_in_commit, TMO_CYC);
        end
`else
        setup_w[0] = $urandom;
        send_setup(1);
        repeat (100) @(negedge local_clk);
        n_vec++;
        if (buf_in_commit !== 1'b1 || err_timeout !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL no_timeout: got commit=%b err=%b busy=%b required 1 0 1",
                     buf_in_commit, err_timeout, busy);
        end
        do_commit(4);
        respond(1'b0, 0);
        finish_resp(1'b0, 0);
`endif
    endtask

    task automatic test_reset_mid_send();
        int t;
        setup_w[0] = $urandom; setup_w[1] = $urandom;
        send_setup(2);
        do_commit(8);
        respond(1'b1, 40);
        t = 0;
        @(negedge local_clk);
        while (tx_valid !== 1'b1 && t < 50) begin t++; @(negedge local_clk); end
        #1;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({rx_ready, buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
             buf_out_addr, buf_out_arm, tx_valid, tx_data, tx_keep, tx_last, tx_zlp, req_stall,
             busy, err_overflow, err_timeout} !== '0) begin
            n_err++; $display("FAIL reset_in_send: got nonzero outputs required all 0");
        end
        buf_out_hasdata = 1'b0;
        exp_ovf = 1'b0;
        repeat (2) @(posedge local_clk);
        #1;
        reset_n = 1'b1;
        clear_mon();
        repeat (20) @(negedge local_clk);
        n_vec++;
        if (txv_cnt != 0 || busy !== 1'b0 || err_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL after_reset: got txv=%0d busy=%b ovf=%b required 0 0 0",
                     txv_cnt, busy, err_overflow);
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; exp_ovf = 1'b0; bp_rand = 1'b0; hold_tx = 1'b0;
        arm_prev = 1'b0;
        clear_mon();
        for (int i = 0; i < 512; i++) resp_mem[i] = '0;
        test_reset();
        test_get_descriptor();
        test_set_address();
        test_stall();
        test_backpressure();
        test_overflow();
        test_random();
        test_timeout();
        test_reset_mid_send();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
